alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU datapath. Accepts one operation request (opcode + two operands) over a valid/ready port.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states and the ABCD marker value.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_OP7 = 3'd7;

    localparam logic [31:0] ABCD_MAGIC = 32'hABCD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one request at a time to a combinational ALU, holds its inputs for SETTLE_CYCLES,
// captures the result and flags, and hands them back over a valid/ready response port.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_z,
    output logic             rsp_abcd,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_abcd,
    input  logic             clr_sticky,
    output logic             abcd_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SC_W-1:0]  r_settle;
    logic             w_accept;
    logic             w_capture;
    logic             w_retire;

    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_z;
    logic             r_rsp_abcd;
    logic [2:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_sticky;
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The capture edge is the one on which the settle counter reads 1.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_settle == SC_W'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_abcd   <= 1'b0;
            r_alu_ctrl   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_settle   <= SC_W'(SETTLE_CYCLES);
                r_alu_ctrl <= req_op;
                r_alu_a    <= req_a;
                r_alu_b    <= req_b;
            end else if (r_state == S_WAIT) begin
                r_settle <= r_settle - SC_W'(1);
            end
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_out;
                r_rsp_z      <= alu_z;
                r_rsp_abcd   <= alu_abcd;
            end else if (w_retire) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_retire) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    // A capture that sees ABCD outranks a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_capture && alu_abcd) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_z       = r_rsp_z;
    assign rsp_abcd    = r_rsp_abcd;
    assign alu_ctrl    = r_alu_ctrl;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign abcd_sticky = r_sticky;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and settle 3) each driving a behavioural ALU.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_ready = 1'b0;
    logic        clr_sticky = 1'b0;

    logic        req_valid1 = 1'b0, req_ready1, rsp_valid1, rsp_z1, rsp_abcd1, alu_z1, alu_abcd1, sticky1;
    logic [31:0] rsp_result1, alu_a1, alu_b1, alu_out1;
    logic [2:0]  alu_ctrl1;
    logic [15:0] op_count1;

    logic        req_valid3 = 1'b0, req_ready3, rsp_valid3, rsp_z3, rsp_abcd3, alu_z3, alu_abcd3, sticky3;
    logic [31:0] rsp_result3, alu_a3, alu_b3, alu_out3;
    logic [2:0]  alu_ctrl3;
    logic [15:0] op_count3;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt1 = 0;
    bit exp_sticky = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRA: return $signed(a) >>> b[4:0];
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_out1  = alu_f(alu_ctrl1, alu_a1, alu_b1);
        alu_z1    = (alu_out1 == 32'd0);
        alu_abcd1 = (alu_out1 == ABCD_MAGIC);
        alu_out3  = alu_f(alu_ctrl3, alu_a3, alu_b3);
        alu_z3    = (alu_out3 == 32'd0);
        alu_abcd3 = (alu_out3 == ABCD_MAGIC);
    end

    alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
        .rsp_z(rsp_z1), .rsp_abcd(rsp_abcd1),
        .alu_ctrl(alu_ctrl1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_out(alu_out1), .alu_z(alu_z1), .alu_abcd(alu_abcd1),
        .clr_sticky(clr_sticky), .abcd_sticky(sticky1), .op_count(op_count1)
    );

    alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
        .rsp_z(rsp_z3), .rsp_abcd(rsp_abcd3),
        .alu_ctrl(alu_ctrl3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_out(alu_out3), .alu_z(alu_z3), .alu_abcd(alu_abcd3),
        .clr_sticky(clr_sticky), .abcd_sticky(sticky3), .op_count(op_count3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full transaction on dut1 starting from an idle negedge; returns what was captured.
    task automatic op1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit clr_cap,
                       output logic [31:0] res, output logic z, output logic abcd);
        int lat;
        chk("op1_req_ready_idle", req_ready1, 1);
        req_valid1 = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        rsp_ready = 1'b0;
        tick();
        req_valid1 = 1'b0;
        clr_sticky = clr_cap;
        chk("op1_wait_no_valid", rsp_valid1, 0);
        chk("op1_wait_not_ready", req_ready1, 0);
        lat = 0;
        while (!rsp_valid1 && lat < 16) begin
            tick();
            clr_sticky = 1'b0;
            lat++;
        end
        chk("op1_latency", lat, 1);
        chk("op1_alu_ctrl", alu_ctrl1, op);
        chk("op1_alu_a", alu_a1, a);
        chk("op1_alu_b", alu_b1, b);
        res = rsp_result1;
        z = rsp_z1;
        abcd = rsp_abcd1;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("op1_hold_valid", rsp_valid1, 1);
            chk("op1_hold_result", {rsp_result1, rsp_z1, rsp_abcd1}, {res, z, abcd});
            chk("op1_hold_not_ready", req_ready1, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt1++;
        chk("op1_retire_valid", rsp_valid1, 0);
        chk("op1_retire_ready", req_ready1, 1);
        chk("op1_op_count", op_count1, exp_cnt1 & 16'hFFFF);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        abcd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] r;
        logic        z, ab;
        int          lat;

        tbl[0] = '{3'd0, 32'd30, 32'd20, 32'd50,       1'b0, 1'b0};
        tbl[1] = '{3'd1, 32'd30, 32'd20, 32'd10,       1'b0, 1'b0};
        tbl[2] = '{3'd2, 32'd30, 32'd20, 32'd20,       1'b0, 1'b0};
        tbl[3] = '{3'd3, 32'd30, 32'd20, 32'd30,       1'b0, 1'b0};
        tbl[4] = '{3'd4, 32'd30, 32'd20, 32'd10,       1'b0, 1'b0};
        tbl[5] = '{3'd5, 32'd30, 32'd20, 32'd31457280, 1'b0, 1'b0};
        tbl[6] = '{3'd6, 32'hFFFFFFFC, 32'd1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[7] = '{3'd7, 32'hFFFFFFFC, 32'd4, 32'd0,   1'b1, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", req_ready1, 1);
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_op_count", op_count1, 0);
        chk("rst_sticky", sticky1, 0);
        chk("rst_alu_ctrl", alu_ctrl1, 0);
        chk("rst_alu_ab", {alu_a1, alu_b1}, 64'd0);
        chk("rst_rsp", {rsp_result1, rsp_z1, rsp_abcd1}, 34'd0);
        chk("rst_req_ready3", req_ready3, 1);

        // Opcode table
        for (int i = 0; i < 8; i++) begin
            op1(tbl[i].op, tbl[i].a, tbl[i].b, i % 3, 1'b0, r, z, ab);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
            chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_abcd", i), ab, tbl[i].abcd);
        end
        chk("tbl_sticky_clear", sticky1, 0);

        // Sticky flag: set, set-wins-over-clear, lone clear
        op1(3'd7, 32'hABCD, 32'd0, 0, 1'b0, r, z, ab);
        chk("abcd_flag", ab, 1);
        chk("abcd_result", r, 32'hABCD);
        chk("abcd_sticky_set", sticky1, 1);
        op1(3'd7, 32'hABCD, 32'd0, 0, 1'b1, r, z, ab);
        chk("abcd_set_wins", sticky1, 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("abcd_lone_clear", sticky1, 0);

        // Backpressure on the settle-3 instance with a competing request held up
        req_op = 3'd0;
        req_a = 32'd100;
        req_b = 32'd23;
        rsp_ready = 1'b0;
        chk("bp_ready_before", req_ready3, 1);
        req_valid3 = 1'b1;
        tick();
        req_op = 3'd1;
        req_a = 32'd7;
        req_b = 32'd7;
        for (int k = 0; k < 3; k++) begin
            chk("bp_wait_valid", rsp_valid3, 0);
            chk("bp_wait_ready", req_ready3, 0);
            tick();
        end
        chk("bp_valid_rise", rsp_valid3, 1);
        chk("bp_result", rsp_result3, 32'd123);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", rsp_valid3, 1);
            chk("bp_hold_rsp", {rsp_result3, rsp_z3, rsp_abcd3}, {32'd123, 1'b0, 1'b0});
            chk("bp_hold_ready", req_ready3, 0);
            chk("bp_alu_held", {alu_ctrl3, alu_a3, alu_b3}, {3'd0, 32'd100, 32'd23});
        end
        req_valid3 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_retire_valid", rsp_valid3, 0);
        chk("bp_retire_ready", req_ready3, 1);
        chk("bp_op_count", op_count3, 1);

        // Reset in the middle of WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt1 = 0;
        exp_sticky = 1'b0;
        req_op = 3'd2;
        req_a = 32'h1234;
        req_b = 32'hFF;
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", rsp_valid3, 0);
        chk("midrst_ready", req_ready3, 1);
        chk("midrst_count", op_count3, 0);
        chk("midrst_alu_a", alu_a3, 0);
        repeat (3) tick();
        chk("midrst_no_late_rsp", rsp_valid3, 0);
        req_op = 3'd0;
        req_a = 32'd30;
        req_b = 32'd20;
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 16) begin
            tick();
            lat++;
        end
        chk("midrst_next_latency", lat, 3);
        chk("midrst_next_result", rsp_result3, 32'd50);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("midrst_next_count", op_count3, 1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b, e;
            bit          cc;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (op == ALU_ADD || op == ALU_OP7) a = ABCD_MAGIC - b;
                else if (op == ALU_SUB) a = b;
            end
            cc = ($urandom_range(0, 5) == 0);
            e = alu_f(op, a, b);
            op1(op, a, b, $urandom_range(0, 3), cc, r, z, ab);
            if (e == ABCD_MAGIC) exp_sticky = 1'b1;
            else if (cc) exp_sticky = 1'b0;
            chk("rnd_result", r, e);
            chk("rnd_z", z, (e == 32'd0));
            chk("rnd_abcd", ab, (e == ABCD_MAGIC));
            chk("rnd_sticky", sticky1, exp_sticky);
            if ($urandom_range(0, 7) == 0) begin
                clr_sticky = 1'b1;
                tick();
                clr_sticky = 1'b0;
                exp_sticky = 1'b0;
                chk("rnd_clear", sticky1, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
